// File: rtl/adc_access_arbiter.sv
// adc_access_arbiter
//
// Shares a single ADC between N_REQ clients. The ADC is granted round-robin: each
// granted client gets a registered conversion request held high for REQ_LEN cycles.
// The arbiter then waits up to TIMEOUT cycles for the ready strobe. On ready it
// captures the sample and pulses ack for the owner; on timeout it pulses err instead.
//
// Ports:
//   clk_i           system clock, rising edge
//   reset_n_i       asynchronous active-low reset
//   req_i           level request per client, held until its ack_o/err_o
//   ack_o           one-cycle pulse, data_o valid for that client
//   err_o           one-cycle pulse, that client's conversion timed out
//   data_o          last captured sample, held until the next capture
//   owner_o         index of the current or last granted client
//   busy_o          high whenever a transaction is in progress
//   adc_data_req_o  registered ADC conversion request
//   adc_data_rdy_i  ADC ready strobe
//   adc_data_i      ADC sample, valid while adc_data_rdy_i is high
module adc_access_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned REQ_LEN = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [N_REQ-1:0]           req_i,
  output logic [N_REQ-1:0]           ack_o,
  output logic [N_REQ-1:0]           err_o,
  output logic [DATA_W-1:0]          data_o,
  output logic [$clog2(N_REQ)-1:0]   owner_o,
  output logic                       busy_o,
  output logic                       adc_data_req_o,
  input  logic                       adc_data_rdy_i,
  input  logic [DATA_W-1:0]          adc_data_i
);

  localparam int unsigned OwnerW = $clog2(N_REQ);
  // One extra bit so ptr + offset never wraps before the modulo correction.
  localparam int unsigned CandW  = OwnerW + 1;
  localparam int unsigned CntW   = 16;

  localparam logic [CandW-1:0]  NReqC      = CandW'(N_REQ);
  localparam logic [OwnerW-1:0] OwnerLast  = OwnerW'(N_REQ - 1);
  localparam logic [CntW-1:0]   ReqLast    = CntW'(REQ_LEN - 1);
  localparam logic [CntW-1:0]   WaitLast   = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [OwnerW-1:0]   ptr_q, ptr_d;
  logic [OwnerW-1:0]   owner_q, owner_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic [N_REQ-1:0]    err_q, err_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;
  logic                adc_req_q, adc_req_d;

  logic                grant_valid;
  logic [OwnerW-1:0]   grant_idx;
  logic [CandW-1:0]    cand;

  // Round-robin search: ptr, ptr+1, ... mod N_REQ; the first requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_q} + CandW'(i);
      if (cand >= NReqC) begin
        cand = cand - NReqC;
      end
      if (!grant_valid && req_i[cand[OwnerW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[OwnerW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    ack_d     = '0;
    err_d     = '0;
    data_d    = data_q;
    adc_req_d = adc_req_q;

    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          owner_d   = grant_idx;
          state_d   = StReq;
          adc_req_d = 1'b1;
          cnt_d     = '0;
        end
      end

      // cnt counts completed request cycles; drop after the REQ_LEN-th.
      StReq: begin
        if (cnt_q == ReqLast) begin
          adc_req_d = 1'b0;
          state_d   = StWait;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // At most TIMEOUT wait cycles; ready in the last one still wins over abort.
      StWait: begin
        if (adc_data_rdy_i) begin
          data_d         = adc_data_i;
          ack_d[owner_q] = 1'b1;
          state_d        = StDone;
        end else if (cnt_q == WaitLast) begin
          err_d[owner_q] = 1'b1;
          state_d        = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // ack/err pulse is visible in this cycle; advance fairness pointer past owner.
      StDone: begin
        ptr_d   = (owner_q == OwnerLast) ? '0 : owner_q + 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ptr_q     <= '0;
      owner_q   <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      adc_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      adc_req_q <= adc_req_d;
    end
  end

  assign ack_o          = ack_q;
  assign err_o          = err_q;
  assign data_o         = data_q;
  assign owner_o        = owner_q;
  assign busy_o         = busy_q;
  assign adc_data_req_o = adc_req_q;

endmodule

// File: tb/tb_adc_access_arbiter.sv
module tb_adc_access_arbiter;

  localparam int N  = 4;
  localparam int DW = 12;
  localparam int RL = 2;
  localparam int TO = 8;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [N-1:0]  req_i;
  logic [N-1:0]  ack_o;
  logic [N-1:0]  err_o;
  logic [DW-1:0] data_o;
  logic [1:0]    owner_o;
  logic          busy_o;
  logic          adc_data_req_o;
  logic          adc_data_rdy_i;
  logic [DW-1:0] adc_data_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: round-robin pointer and last captured sample.
  int            m_ptr;
  logic [DW-1:0] m_data;

  always #5 clk_i = ~clk_i;

  adc_access_arbiter #(
    .N_REQ   (N),
    .DATA_W  (DW),
    .REQ_LEN (RL),
    .TIMEOUT (TO)
  ) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .req_i          (req_i),
    .ack_o          (ack_o),
    .err_o          (err_o),
    .data_o         (data_o),
    .owner_o        (owner_o),
    .busy_o         (busy_o),
    .adc_data_req_o (adc_data_req_o),
    .adc_data_rdy_i (adc_data_rdy_i),
    .adc_data_i     (adc_data_i)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int model_winner(input logic [N-1:0] req, input int ptr);
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (ptr + i) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  // One full transaction starting in an IDLE cycle with req_i already set.
  // d = WAIT cycle (0-based) in which ready is driven; d >= TO means ready comes
  // only after the timeout (in DONE or the following IDLE cycle) and must be ignored.
  task automatic run_txn(input string name, input int d, input logic [DW-1:0] sample,
                         input bit withdraw);
    int            w;
    int            kd;
    int            rdy_k;
    logic [DW-1:0] exp_data;
    logic [N-1:0]  pulse;
    logic [23:0]   exp_v;
    logic [23:0]   obs_v;
    w = model_winner(req_i, m_ptr);
    if (w < 0) begin
      n_checks++;
      $display("FAIL %s: no requester, got req_i=%b want nonzero", name, req_i);
      return;
    end
    kd       = (d < TO) ? RL + 2 + d : RL + 1 + TO;
    rdy_k    = RL + 1 + d;
    exp_data = m_data;
    // Ready noise in the IDLE cycle must be ignored.
    adc_data_rdy_i = 1'($urandom_range(0, 1));
    adc_data_i     = DW'($urandom);
    for (int k = 1; k <= kd + 1; k++) begin
      tick();
      if (k == kd && d < TO) exp_data = sample;
      pulse = (k == kd) ? N'(1 << w) : '0;
      exp_v = {(k <= RL), (k <= kd), (d < TO) ? pulse : 4'b0, (d >= TO) ? pulse : 4'b0,
               2'(w), exp_data};
      obs_v = {adc_data_req_o, busy_o, ack_o, err_o, owner_o, data_o};
      n_checks++;
      if (obs_v !== exp_v) begin
        $display("FAIL %s cyc %0d: got req=%b busy=%b ack=%b err=%b owner=%0d data=%h, want req=%b busy=%b ack=%b err=%b owner=%0d data=%h",
                 name, k, obs_v[23], obs_v[22], obs_v[21:18], obs_v[17:14], obs_v[13:12],
                 obs_v[11:0], exp_v[23], exp_v[22], exp_v[21:18], exp_v[17:14],
                 exp_v[13:12], exp_v[11:0]);
      end else begin
        n_pass++;
      end
      if (k == 1 && withdraw) req_i[w] = 1'b0;
      if (k == kd) req_i[w] = 1'b0;
      if (k == rdy_k) begin
        adc_data_rdy_i = 1'b1;
        adc_data_i     = sample;
      end else if (k <= RL || k >= kd) begin
        adc_data_rdy_i = 1'($urandom_range(0, 1));
        adc_data_i     = DW'($urandom);
      end else begin
        adc_data_rdy_i = 1'b0;
        adc_data_i     = DW'($urandom);
      end
    end
    if (d < TO) m_data = sample;
    m_ptr = (w + 1) % N;
  endtask

  task automatic test_reset();
    logic [23:0] obs_v;
    reset_n_i      = 1'b1;
    req_i          = '0;
    adc_data_rdy_i = 1'b0;
    adc_data_i     = '0;
    #3;
    reset_n_i = 1'b0;
    #1;
    obs_v = {adc_data_req_o, busy_o, ack_o, err_o, owner_o, data_o};
    n_checks++;
    if (obs_v !== 24'h0) $display("FAIL reset_async: got %h want %h", obs_v, 24'h0);
    else n_pass++;
    tick();
    tick();
    #2;
    reset_n_i = 1'b1;
    tick();
    obs_v = {adc_data_req_o, busy_o, ack_o, err_o, owner_o, data_o};
    n_checks++;
    if (obs_v !== 24'h0) $display("FAIL reset_idle: got %h want %h", obs_v, 24'h0);
    else n_pass++;
    m_ptr  = 0;
    m_data = '0;
  endtask

  task automatic test_round_robin();
    req_i = 4'b1111;
    for (int i = 0; i < N; i++) begin
      run_txn("rr_all", $urandom_range(0, TO - 1), DW'($urandom), 1'b0);
    end
    req_i = 4'b0101;
    run_txn("rr_reraise_a", $urandom_range(0, TO - 1), DW'($urandom), 1'b0);
    run_txn("rr_reraise_b", $urandom_range(0, TO - 1), DW'($urandom), 1'b0);
  endtask

  task automatic test_single();
    req_i = 4'b0001;
    run_txn("single", 2, 12'hA5C, 1'b0);
  endtask

  task automatic test_timeout();
    req_i = 4'b0100;
    run_txn("timeout", TO, DW'($urandom), 1'b0);
    req_i = 4'b1001;
    run_txn("after_timeout_a", 1, DW'($urandom), 1'b0);
    run_txn("after_timeout_b", 0, DW'($urandom), 1'b0);
  endtask

  task automatic test_boundary();
    req_i = 4'b0010;
    run_txn("rdy_at_timeout", TO - 1, DW'($urandom), 1'b0);
    req_i = 4'b0010;
    run_txn("rdy_after_timeout", TO + 1, DW'($urandom), 1'b0);
  endtask

  task automatic test_withdraw();
    req_i = 4'b0101;
    run_txn("withdraw", $urandom_range(0, TO - 1), DW'($urandom), 1'b1);
    run_txn("withdraw_rest", $urandom_range(0, TO - 1), DW'($urandom), 1'b0);
  endtask

  task automatic test_async_reset();
    logic [23:0] obs_v;
    req_i          = 4'b1000;
    adc_data_rdy_i = 1'b0;
    for (int k = 1; k <= RL + 2; k++) tick();
    // Second WAIT cycle: busy, request already dropped.
    n_checks++;
    if ({busy_o, adc_data_req_o} !== 2'b10)
      $display("FAIL pre_reset_wait: got busy/req=%b want 10", {busy_o, adc_data_req_o});
    else n_pass++;
    #2;
    reset_n_i = 1'b0;
    #1;
    obs_v = {adc_data_req_o, busy_o, ack_o, err_o, owner_o, data_o};
    n_checks++;
    if (obs_v !== 24'h0) $display("FAIL reset_mid_wait: got %h want %h", obs_v, 24'h0);
    else n_pass++;
    tick();
    obs_v = {adc_data_req_o, busy_o, ack_o, err_o, owner_o, data_o};
    n_checks++;
    if (obs_v !== 24'h0) $display("FAIL reset_held: got %h want %h", obs_v, 24'h0);
    else n_pass++;
    #2;
    reset_n_i = 1'b1;
    req_i     = 4'b0010;
    m_ptr     = 0;
    m_data    = '0;
    run_txn("post_reset", $urandom_range(0, TO - 1), DW'($urandom), 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      req_i = N'($urandom_range(1, (1 << N) - 1));
      run_txn("random", $urandom_range(0, TO + 1), DW'($urandom), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_timeout();
    test_boundary();
    test_withdraw();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_access_arbiter.md
Name: adc_access_arbiter

Overview:
- Shares one ADC (2-cycle request pulse, ready strobe, 12-bit sample) between N_REQ client blocks, e.g. several averaging acquisition channels.
- Grants the ADC round-robin and generates the request pulse.
- Waits for ready with a timeout, captures the sample and returns it to the granted client with a one-cycle ack, or an err pulse on timeout.

Parameters:
- N_REQ, 4, number of clients; minimum 2.
- DATA_W, 12, ADC sample width.
- REQ_LEN, 2, cycles adc_data_req_o is held high per conversion; minimum 2.
- TIMEOUT, 255, cycles spent in WAIT without adc_data_rdy_i before aborting; 1..65535.

Ports:
- clk_i  in  1  single system clock, rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- req_i  in  N_REQ  level request per client; held until that client's ack_o or err_o.
- ack_o  out  N_REQ  one-cycle pulse: data_o is valid for that client.
- err_o  out  N_REQ  one-cycle pulse: that client's conversion timed out.
- data_o  out  DATA_W  last captured sample; held until the next capture.
- owner_o  out  max(1,clog2(N_REQ))  index of the current or last granted client.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- adc_data_req_o  out  1  ADC conversion request, registered.
- adc_data_rdy_i  in  1  ADC ready strobe.
- adc_data_i  in  DATA_W  ADC sample; valid while adc_data_rdy_i is high.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: adc_data_req_o=0, ack_o=0, err_o=0, data_o=0, owner_o=0, busy_o=0, state=IDLE, rr pointer=0, counters=0.
- Reset mid-operation: an abandoned transaction produces no ack or err; the ADC sees its request drop immediately.
- All outputs are registered.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Arbitrate combinationally over req_i.
  - Search indices ptr, ptr+1, … mod N_REQ; the first set bit wins.
  - On a winner: owner_o <= winner, state <= REQ, adc_data_req_o <= 1, counter cleared.
  - No request: stay in IDLE.
- REQ:
  - adc_data_req_o stays high for exactly REQ_LEN cycles, then drops.
  - On the drop edge: state <= WAIT, counter cleared.
- WAIT:
  - adc_data_rdy_i=1: data_o <= adc_data_i, ack_o[owner] <= 1, state <= DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT: err_o[owner] <= 1, data_o unchanged, state <= DONE.
  - If rdy and timeout occur in the same cycle, rdy wins.
- DONE:
  - The ack or err pulse is high for this single cycle, then cleared.
  - ptr <= (owner+1) mod N_REQ.
  - state <= IDLE.
- Latency: req_i sampled high in IDLE at cycle t → adc_data_req_o high in cycles t+1..t+REQ_LEN. WAIT runs from t+REQ_LEN+1. rdy in cycle w → ack_o high in cycle w+1.
- Minimum back-to-back period: REQ_LEN+3 cycles when rdy arrives in the first WAIT cycle.
- Client rule: a client drops req_i on the clock edge that ends its ack/err cycle. Because IDLE samples req_i the cycle after DONE, a finished client is not re-granted unless it still requests.
- adc_data_rdy_i outside WAIT is ignored: no capture, no pulse.
- A request withdrawn during REQ/WAIT does not abort the conversion; ack/err is still issued and the client ignores it.
- Only one bit of ack_o|err_o is ever high, and never both ack and err together.

Test Plan:
- Single client: N_REQ=4, req_i=4'b0001, rdy in the 3rd WAIT cycle with adc_data_i=12'hA5C.
  - adc_data_req_o is high exactly 2 cycles.
  - ack_o=4'b0001 for 1 cycle, data_o=12'hA5C, owner_o=0.
  - busy_o falls the cycle after ack.
- Round-robin fairness: req_i=4'b1111 held, each client dropping after its own ack.
  - Grants occur in order 0,1,2,3.
  - Re-raising 0 and 2 after the ptr has reached 0 grants 0 then 2.
  - ack_o is never multi-hot.
- Timeout: TIMEOUT=8, req_i=4'b0100, rdy never asserted.
  - err_o=4'b0100 exactly 8 cycles after entering WAIT.
  - ack_o stays 0 and data_o keeps its previous value.
  - The next grant goes to client 3 first if it is requesting.
- Boundary:
  - rdy asserted in the same cycle the counter hits TIMEOUT → ack (not err), data captured.
  - rdy pulses during IDLE and REQ are ignored.
- Async reset: assert reset_n_i=0 mid-WAIT, between clock edges.
  - adc_data_req_o, ack_o, err_o, busy_o and data_o go to 0 immediately.
  - After release with req_i=4'b0010, client 1 is granted first (ptr=0).
- Withdrawn request: client 2 drops req_i during REQ.
  - Conversion completes and ack_o[2] still pulses.
  - The arbiter then serves the remaining requesters.
